// File: rtl/fsk_pkg.sv
// Shared definitions for the FSK transmit/receive family: FSM state encoding,
// elaboration helpers and the default NCO tuning constants.
package fsk_pkg;

   localparam logic [31:0] FSK_F_BASE_DEFAULT = 32'h0100_0000;
   localparam logic [31:0] FSK_F_STEP_DEFAULT = 32'h0080_0000;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } mod_state_t;

   // Ceiling log2 for elaboration-time width calculation; clog2(1) = 0.
   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      v = value - 1;
      while (v > 0) begin
         result = result + 1;
         v = v >>> 1;
      end
      return result;
   endfunction

   // Modulation orders the modulator/demodulator pair supports.
   function automatic bit is_legal_m(input int m);
      return (m == 2) || (m == 4) || (m == 8) || (m == 16);
   endfunction

endpackage

// File: rtl/sine_lut.sv
// Full-period signed sine table with a registered read port. The table is
// computed at elaboration so the same block serves modulator and correlators.
module sine_lut #(
   parameter int ADDR_W = 10,
   parameter int OUT_W  = 16
) (
   input  logic                    clk,
   input  logic [ADDR_W-1:0]       addr,
   output logic signed [OUT_W-1:0] sample
);

   localparam int  DEPTH = 1 << ADDR_W;
   localparam real PI    = 3.14159265358979323846;

   // round(A * sin(2*pi*k/DEPTH)), halves rounded away from zero.
   function automatic logic signed [OUT_W-1:0] sine_entry(input int k);
      real amp;
      real v;
      amp = real'((1 << (OUT_W - 1)) - 1);
      v   = amp * $sin(2.0 * PI * real'(k) / real'(DEPTH));
      if (v >= 0.0)
         return OUT_W'($rtoi(v + 0.5));
      else
         return OUT_W'(-$rtoi(-v + 0.5));
   endfunction

   logic signed [OUT_W-1:0] rom [DEPTH];

   for (genvar k = 0; k < DEPTH; k++) begin : g_rom
      assign rom[k] = sine_entry(k);
   end

   // Registered read: one cycle from address to sample.
   always_ff @(posedge clk) begin
      sample <= rom[addr];
   end

endmodule

// File: rtl/mfsk_modulator.sv
// Phase-continuous M-ary FSK modulator. One symbol per handshake selects an
// NCO tuning word; SAMPLES_PER_SYM sine samples are emitted per symbol from a
// phase accumulator feeding the sine table. The phase is carried across
// back-to-back symbols and only cleared when the symbol stream runs dry.
//
// Handshake: a symbol transfers on a rising edge where sym_valid && sym_ready.
// sym_ready is a function of state and sample counter only (never of
// sym_valid): high in IDLE and on the last sample slot of a symbol in RUN.
module mfsk_modulator
   import fsk_pkg::*;
#(
   parameter int                 M_ORDER         = 16,
   parameter int                 PHASE_W         = 32,
   parameter int                 LUT_ADDR_W      = 10,
   parameter int                 OUT_W           = 16,
   parameter int                 SAMPLES_PER_SYM = 64,
   parameter logic [PHASE_W-1:0] F_BASE          = PHASE_W'(FSK_F_BASE_DEFAULT),
   parameter logic [PHASE_W-1:0] F_STEP          = PHASE_W'(FSK_F_STEP_DEFAULT),
   localparam int                SYM_W           = clog2(M_ORDER)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [SYM_W-1:0]        sym_data,
   input  logic                    sym_valid,
   output logic                    sym_ready,
   output logic signed [OUT_W-1:0] sine_out,
   output logic                    out_valid,
   output logic                    active,
   output logic                    underrun
);

   localparam int          CNT_W    = clog2(SAMPLES_PER_SYM);
   localparam logic [63:0] FTW_MAX  = 64'(F_BASE) + 64'(M_ORDER - 1) * 64'(F_STEP);
   localparam logic [63:0] FTW_NYQ  = 64'd1 << (PHASE_W - 1);

   if (!is_legal_m(M_ORDER)) begin : g_bad_order
      $error("mfsk_modulator: M_ORDER must be 2, 4, 8 or 16");
   end
   if (FTW_MAX >= FTW_NYQ) begin : g_bad_nyquist
      $error("mfsk_modulator: highest tone reaches Nyquist");
   end
   if (SAMPLES_PER_SYM < 2) begin : g_bad_sps
      $error("mfsk_modulator: SAMPLES_PER_SYM must be at least 2");
   end

   mod_state_t              state_q;
   mod_state_t              state_d;
   logic [CNT_W-1:0]        cnt_q;
   logic [PHASE_W-1:0]      phase_q;
   logic [PHASE_W-1:0]      ftw_reg;
   logic [PHASE_W-1:0]      ftw_d;
   logic                    last_slot;
   logic                    xfer;
   logic signed [OUT_W-1:0] lut_sample;

   // Handshake, symbol-to-tuning-word map and next-state decision.
   always_comb begin
      state_d   = state_q;
      last_slot = (cnt_q == CNT_W'(SAMPLES_PER_SYM - 1));
      sym_ready = (state_q == ST_IDLE) || last_slot;
      xfer      = sym_valid && sym_ready;
      ftw_d     = F_BASE + PHASE_W'(sym_data) * F_STEP;
      case (state_q)
         ST_IDLE: if (xfer) state_d = ST_RUN;
         ST_RUN:  if (last_slot && !xfer) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State, counter, tuning word and phase accumulator; phase survives a
   // symbol boundary with a transfer and is cleared on an underrun.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         phase_q   <= '0;
         ftw_reg   <= '0;
         out_valid <= 1'b0;
         underrun  <= 1'b0;
      end else begin
         state_q   <= state_d;
         out_valid <= (state_q == ST_RUN);
         underrun  <= (state_q == ST_RUN) && last_slot && !xfer;
         if (xfer) ftw_reg <= ftw_d;
         if (state_q == ST_RUN) begin
            if (last_slot) begin
               cnt_q   <= '0;
               phase_q <= xfer ? (phase_q + ftw_reg) : '0;
            end else begin
               cnt_q   <= cnt_q + CNT_W'(1);
               phase_q <= phase_q + ftw_reg;
            end
         end else begin
            cnt_q   <= '0;
            phase_q <= '0;
         end
      end
   end

   sine_lut #(
      .ADDR_W (LUT_ADDR_W),
      .OUT_W  (OUT_W)
   ) u_sine_lut (
      .clk    (clk),
      .addr   (phase_q[PHASE_W-1 -: LUT_ADDR_W]),
      .sample (lut_sample)
   );

   // Sample output is forced to zero whenever it is not valid.
   always_comb begin
      active   = (state_q == ST_RUN);
      sine_out = out_valid ? lut_sample : '0;
   end

endmodule
